// File: rtl/qram_matrix_loader_pkg.sv
// Shared constants and types for the complex matrix store write-side loader.
// Element width, matrix geometry, FSM encoding and write-enable masks live here.
package qram_matrix_loader_pkg;

  localparam int WORD_LEN   = 16;
  localparam int MATRIX_DIM = 4;
  localparam int ADDR_BITS  = 4;

  localparam int ELEM_COUNT = MATRIX_DIM * MATRIX_DIM;

  // Address of the final element of a load; reaching it ends the load
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(ELEM_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // we bit order: [0]=M1 real, [1]=M2 real, [2]=M1 imag, [3]=M2 imag
  localparam logic [3:0] WE_M1 = 4'b0101;
  localparam logic [3:0] WE_M2 = 4'b1010;

endpackage

// File: rtl/qram_matrix_loader.sv
// Streams one MATRIX_DIM x MATRIX_DIM complex matrix per start pulse into M1 or M2,
// row-major, with registered write enables, data and addresses (1-cycle write latency).
module qram_matrix_loader
  import qram_matrix_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mat_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_LEN-1:0]  in_real,
  input  logic [WORD_LEN-1:0]  in_imag,
  input  logic                 in_last,
  output logic [3:0]           we,
  output logic [WORD_LEN-1:0]  data_m1_real,
  output logic [WORD_LEN-1:0]  data_m1_imag,
  output logic [WORD_LEN-1:0]  data_m2_real,
  output logic [WORD_LEN-1:0]  data_m2_imag,
  output logic [ADDR_BITS-1:0] Dir_M1,
  output logic [ADDR_BITS-1:0] Dir_M2,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] count_q, count_d;
  logic                 sel_q, sel_d;
  logic [3:0]           we_q, we_d;
  logic [WORD_LEN-1:0]  m1_real_q, m1_real_d;
  logic [WORD_LEN-1:0]  m1_imag_q, m1_imag_d;
  logic [WORD_LEN-1:0]  m2_real_q, m2_real_d;
  logic [WORD_LEN-1:0]  m2_imag_q, m2_imag_d;
  logic [ADDR_BITS-1:0] dir_m1_q, dir_m1_d;
  logic [ADDR_BITS-1:0] dir_m2_q, dir_m2_d;
  logic                 err_q, err_d;

  logic accept;
  logic at_last;

  assign accept  = in_valid & in_ready;
  assign at_last = (count_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q == LOAD);
    done     = (state_q == DONE);
  end

  // Load length is fixed by the counter; in_last only flags a mismatch, never ends a load
  always_comb begin
    count_d   = count_q;
    sel_d     = sel_q;
    we_d      = '0;
    err_d     = 1'b0;
    m1_real_d = m1_real_q;
    m1_imag_d = m1_imag_q;
    m2_real_d = m2_real_q;
    m2_imag_d = m2_imag_q;
    dir_m1_d  = dir_m1_q;
    dir_m2_d  = dir_m2_q;

    if (state_q == IDLE && start) begin
      sel_d = mat_sel;
    end

    if (state_q != LOAD) begin
      count_d = '0;
    end

    if (accept) begin
      count_d = at_last ? '0 : count_q + ADDR_BITS'(1);
      err_d   = in_last ^ at_last;
      if (sel_q) begin
        we_d      = WE_M2;
        m2_real_d = in_real;
        m2_imag_d = in_imag;
        dir_m2_d  = count_q;
      end else begin
        we_d      = WE_M1;
        m1_real_d = in_real;
        m1_imag_d = in_imag;
        dir_m1_d  = count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      sel_q     <= 1'b0;
      we_q      <= '0;
      err_q     <= 1'b0;
      m1_real_q <= '0;
      m1_imag_q <= '0;
      m2_real_q <= '0;
      m2_imag_q <= '0;
      dir_m1_q  <= '0;
      dir_m2_q  <= '0;
    end else begin
      count_q   <= count_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      err_q     <= err_d;
      m1_real_q <= m1_real_d;
      m1_imag_q <= m1_imag_d;
      m2_real_q <= m2_real_d;
      m2_imag_q <= m2_imag_d;
      dir_m1_q  <= dir_m1_d;
      dir_m2_q  <= dir_m2_d;
    end
  end

  assign we           = we_q;
  assign err          = err_q;
  assign data_m1_real = m1_real_q;
  assign data_m1_imag = m1_imag_q;
  assign data_m2_real = m2_real_q;
  assign data_m2_imag = m2_imag_q;
  assign Dir_M1       = dir_m1_q;
  assign Dir_M2       = dir_m2_q;

endmodule
